mem_cfg_trap: RTL and testbench

//  Configuration guard and runtime hazard monitor for generic_ram.
//  - Elaboration time: rejects illegal parameter sets. DATA_WIDTH must be a

---
 rtl/mem_cfg_trap_pkg.sv | 23 ++
 rtl/sat_err_counter.sv | 32 +++
 rtl/mem_cfg_trap.sv | 72 +++++++
 tb/tb_mem_cfg_trap.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_cfg_trap_pkg.sv
// Shared types and helpers for the generic_ram configuration guard.
package mem_cfg_pkg;

  typedef enum logic {
    MEM_BRAM = 1'b0,
    MEM_REG  = 1'b1
  } mem_type_e;

  localparam int unsigned ADDR_WIDTH_MIN = 1;
  localparam int unsigned ADDR_WIDTH_MAX = 24;
  localparam int unsigned CNT_WIDTH_MIN  = 1;
  localparam int unsigned CNT_WIDTH_MAX  = 32;

  // Anything other than "REG" maps to BRAM; legality is checked separately.
  function automatic mem_type_e str2memtype(input string s);
    return (s == "REG") ? MEM_REG : MEM_BRAM;
  endfunction

  function automatic bit mem_type_legal(input string s);
    return (s == "BRAM") || (s == "REG");
  endfunction

endpackage

// File: rtl/sat_err_counter.sv
// Sticky error flag plus saturating event counter.
module sat_err_counter
  import mem_cfg_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 ev,
  output logic                 flag,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= 1'b0;
      cnt  <= '0;
    end else if (ev) begin
      // An event outranks a same-cycle clear: the cleared count restarts at 1.
      flag <= 1'b1;
      if (clr)
        cnt <= CNT_WIDTH'(1);
      else if (cnt != '1)
        cnt <= cnt + CNT_WIDTH'(1);
    end else if (clr) begin
      flag <= 1'b0;
      cnt  <= '0;
    end
  end

endmodule

// File: rtl/mem_cfg_trap.sv
// Elaboration-time parameter guard and runtime hazard monitor for generic_ram.
module mem_cfg_trap
  import mem_cfg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter string       MEM_TYPE   = "BRAM",
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    err_clr,
  output logic                    cfg_ok,
  output logic                    mem_type,
  output logic                    err_empty_be,
  output logic                    err_collide,
  output logic [CNT_WIDTH-1:0]    empty_be_cnt,
  output logic [CNT_WIDTH-1:0]    collide_cnt
);

  localparam mem_type_e MEM_TYPE_E = str2memtype(MEM_TYPE);

  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH == 0) begin : g_bad_dw
    $fatal(1, "mem_cfg_trap: invalid_data_width DATA_WIDTH=%0d", DATA_WIDTH);
  end
  if (!mem_type_legal(MEM_TYPE)) begin : g_bad_mt
    $fatal(1, "mem_cfg_trap: unsupported_MEM_TYPE %s", MEM_TYPE);
  end
  if (ADDR_WIDTH < ADDR_WIDTH_MIN || ADDR_WIDTH > ADDR_WIDTH_MAX) begin : g_bad_aw
    $fatal(1, "mem_cfg_trap: invalid_addr_width ADDR_WIDTH=%0d", ADDR_WIDTH);
  end
  if (CNT_WIDTH < CNT_WIDTH_MIN || CNT_WIDTH > CNT_WIDTH_MAX) begin : g_bad_cw
    $fatal(1, "mem_cfg_trap: invalid_cnt_width CNT_WIDTH=%0d", CNT_WIDTH);
  end

  assign cfg_ok   = 1'b1;
  assign mem_type = MEM_TYPE_E;

  logic be_any;
  logic empty_ev;
  logic collide_ev;

  // The two events are disjoint by construction on be_any.
  always_comb begin
    be_any     = (wr_be != '0);
    empty_ev   = wr_en && !be_any;
    collide_ev = wr_en && be_any && (wr_addr == rd_addr);
  end

  sat_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_empty_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (err_clr),
    .ev   (empty_ev),
    .flag (err_empty_be),
    .cnt  (empty_be_cnt)
  );

  sat_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_collide_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (err_clr),
    .ev   (collide_ev),
    .flag (err_collide),
    .cnt  (collide_cnt)
  );

endmodule

// File: tb/tb_mem_cfg_trap.sv
// Directed self-checking bench for mem_cfg_trap (32-bit REG and 4-bit-counter BRAM builds).
module tb_mem_cfg_trap;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [3:0]  wr_addr;
  logic [3:0]  rd_addr;
  logic        err_clr;

  logic        cfg_ok, mem_type, err_empty_be, err_collide;
  logic [15:0] empty_be_cnt, collide_cnt;

  logic        s_cfg_ok, s_mem_type, s_err_empty_be, s_err_collide;
  logic [3:0]  s_empty_be_cnt, s_collide_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_cfg_trap #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4),
    .MEM_TYPE   ("REG"),
    .CNT_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_be        (wr_be),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .err_clr      (err_clr),
    .cfg_ok       (cfg_ok),
    .mem_type     (mem_type),
    .err_empty_be (err_empty_be),
    .err_collide  (err_collide),
    .empty_be_cnt (empty_be_cnt),
    .collide_cnt  (collide_cnt)
  );

  mem_cfg_trap #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4),
    .MEM_TYPE   ("BRAM"),
    .CNT_WIDTH  (4)
  ) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_be        (wr_be),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .err_clr      (err_clr),
    .cfg_ok       (s_cfg_ok),
    .mem_type     (s_mem_type),
    .err_empty_be (s_err_empty_be),
    .err_collide  (s_err_collide),
    .empty_be_cnt (s_empty_be_cnt),
    .collide_cnt  (s_collide_cnt)
  );

  // Inputs are driven 1 time unit after a rising edge; outputs sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] be,
                       input logic [3:0] wa, input logic [3:0] ra);
    wr_en = en; wr_be = be; wr_addr = wa; rd_addr = ra;
  endtask

  task automatic test_reset();
    rst = 1'b1; err_clr = 1'b0; drive(1'b0, 4'h0, 4'h0, 4'h0);
    step(); step();
    rst = 1'b0;
    step();
    n_tests++;
    if (cfg_ok !== 1'b1 || mem_type !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cfg: cfg_ok=%b mem_type=%b, want 1 1", cfg_ok, mem_type);
    end
    n_tests++;
    if (s_cfg_ok !== 1'b1 || s_mem_type !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cfg_bram: cfg_ok=%b mem_type=%b, want 1 0", s_cfg_ok, s_mem_type);
    end
    n_tests++;
    if (err_empty_be !== 1'b0 || err_collide !== 1'b0 ||
        empty_be_cnt !== 16'd0 || collide_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: flags=%b%b cnts=%0d/%0d, want 00 0/0",
               err_empty_be, err_collide, empty_be_cnt, collide_cnt);
    end
  endtask

  task automatic test_collide();
    drive(1'b1, 4'hF, 4'd3, 4'd3);
    step();
    drive(1'b0, 4'hF, 4'd3, 4'd3);
    n_tests++;
    if (err_collide !== 1'b1 || collide_cnt !== 16'd1 || err_empty_be !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_once: err_collide=%b cnt=%0d err_empty=%b, want 1 1 0",
               err_collide, collide_cnt, err_empty_be);
    end
    // Write to a different address than the read is no hazard.
    drive(1'b1, 4'h1, 4'd4, 4'd3);
    step();
    drive(1'b0, 4'h0, 4'd0, 4'd0);
    step();
    n_tests++;
    if (err_collide !== 1'b1 || collide_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL collide_hold: err_collide=%b cnt=%0d, want 1 1", err_collide, collide_cnt);
    end
  endtask

  task automatic test_empty();
    drive(1'b1, 4'h0, 4'd5, 4'd5);
    for (int unsigned i = 0; i < 3; i++) step();
    drive(1'b0, 4'h0, 4'd0, 4'd0);
    n_tests++;
    if (err_empty_be !== 1'b1 || empty_be_cnt !== 16'd3 || collide_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL empty_three: err_empty=%b cnt=%0d collide_cnt=%0d, want 1 3 1",
               err_empty_be, empty_be_cnt, collide_cnt);
    end
    drive(1'b0, 4'hF, 4'd2, 4'd2);
    step();
    drive(1'b0, 4'h0, 4'd7, 4'd7);
    step();
    n_tests++;
    if (empty_be_cnt !== 16'd3 || collide_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL no_wr_en: empty_cnt=%0d collide_cnt=%0d, want 3 1",
               empty_be_cnt, collide_cnt);
    end
  endtask

  task automatic test_clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_tests++;
    if (err_empty_be !== 1'b0 || err_collide !== 1'b0 ||
        empty_be_cnt !== 16'd0 || collide_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL clr_alone: flags=%b%b cnts=%0d/%0d, want 00 0/0",
               err_empty_be, err_collide, empty_be_cnt, collide_cnt);
    end
    drive(1'b1, 4'h3, 4'd9, 4'd9);
    step(); step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    drive(1'b0, 4'h0, 4'd0, 4'd0);
    n_tests++;
    if (err_collide !== 1'b1 || collide_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL clr_with_event: err_collide=%b cnt=%0d, want 1 1", err_collide, collide_cnt);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_tests++;
    if (err_collide !== 1'b0 || collide_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL clr_after: err_collide=%b cnt=%0d, want 0 0", err_collide, collide_cnt);
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 4'h8, 4'd12, 4'd12);
    for (int unsigned i = 0; i < 15; i++) step();
    n_tests++;
    if (s_collide_cnt !== 4'hF) begin
      n_fail++;
      $display("FAIL sat_reach: cnt=%h, want f", s_collide_cnt);
    end
    for (int unsigned i = 0; i < 5; i++) step();
    drive(1'b0, 4'h0, 4'd0, 4'd0);
    n_tests++;
    if (s_collide_cnt !== 4'hF || s_err_collide !== 1'b1 || s_empty_be_cnt !== 4'h0) begin
      n_fail++;
      $display("FAIL sat_hold: cnt=%h flag=%b empty_cnt=%h, want f 1 0",
               s_collide_cnt, s_err_collide, s_empty_be_cnt);
    end
    n_tests++;
    if (collide_cnt !== 16'd20) begin
      n_fail++;
      $display("FAIL wide_count: cnt=%0d, want 20", collide_cnt);
    end
  endtask

  task automatic test_rst_mid();
    drive(1'b1, 4'h0, 4'd1, 4'd1);
    step(); step(); step();
    n_tests++;
    if (empty_be_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL pre_rst: empty_cnt=%0d, want 3", empty_be_cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (err_empty_be !== 1'b0 || err_collide !== 1'b0 || empty_be_cnt !== 16'd0 ||
        collide_cnt !== 16'd0 || s_collide_cnt !== 4'h0 || cfg_ok !== 1'b1 || mem_type !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: flags=%b%b cnts=%0d/%0d sat=%h cfg=%b%b, want 00 0/0 0 11",
               err_empty_be, err_collide, empty_be_cnt, collide_cnt, s_collide_cnt, cfg_ok, mem_type);
    end
    step();
    n_tests++;
    if (err_empty_be !== 1'b1 || empty_be_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL resume_1: flag=%b cnt=%0d, want 1 1", err_empty_be, empty_be_cnt);
    end
    step();
    drive(1'b0, 4'h0, 4'd0, 4'd0);
    n_tests++;
    if (empty_be_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL resume_2: cnt=%0d, want 2", empty_be_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_collide();
    test_empty();
    test_clr();
    test_saturation();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
